// File: rtl/fetch_stage_pkg.sv
// Shared fetch/execute definitions: widths, reset PC, bubble word and
// the per-cycle fetch action encoding.
package fetch_stage_pkg;

  localparam int PC_W   = 12;
  localparam int INSN_W = 32;

  localparam logic [PC_W-1:0]   RESET_PC = 12'h000;
  localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0000;

  // What the fetch stage does on the coming edge, highest priority first.
  typedef enum logic [1:0] {
    ACT_REDIRECT = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_ADVANCE  = 2'd2
  } fetch_act_e;

  // Sequential PC; wraps silently at the top of the address space.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks the in-flight instruction word while the
// fetch stage is stalled. Clear has priority over load.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [INSN_W-1:0] i_data,
  output logic              o_valid,
  output logic [INSN_W-1:0] o_insn
);

  logic              r_valid;
  logic [INSN_W-1:0] r_insn;

  // Capture the word on load, drop it on clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_insn  <= NOP_INSN;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_insn  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_insn  = r_insn;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem and
// fills the IF/ID register. Redirects flush wrong-path fetches; stalls
// freeze the PC and park the in-flight word in a one-entry hold buffer.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [PC_W-1:0]   redir_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_data,
  output logic              ifid_valid,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [INSN_W-1:0] ifid_insn
);

  logic [PC_W-1:0]   r_pc;
  logic              r_f_valid;
  logic [PC_W-1:0]   r_f_pc;
  logic              r_ifid_valid;
  logic [PC_W-1:0]   r_ifid_pc;
  logic [INSN_W-1:0] r_ifid_insn;

  fetch_act_e        w_act;
  logic              w_hold_valid;
  logic [INSN_W-1:0] w_hold_insn;
  logic              w_hold_load;
  logic              w_hold_clear;
  logic [INSN_W-1:0] w_fetched_insn;

  // Resolve the action for this cycle: redirect beats stall beats advance.
  always_comb begin
    w_act = ACT_ADVANCE;
    if (redir_valid) begin
      w_act = ACT_REDIRECT;
    end else if (stall) begin
      w_act = ACT_STALL;
    end
  end

  // Park the in-flight word once per stall; any non-stall edge empties the
  // buffer (advance consumes it, redirect discards it). Since the PC is
  // frozen while stalled, a second entry is never needed.
  assign w_hold_load  = (w_act == ACT_STALL) && r_f_valid && !w_hold_valid;
  assign w_hold_clear = (w_act != ACT_STALL);

  fetch_hold_buf u_hold_buf (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_data  (imem_data),
    .o_valid (w_hold_valid),
    .o_insn  (w_hold_insn)
  );

  // After a stall the live memory output shows imem[pc], not the word
  // that was in flight, so the parked copy must be used instead.
  assign w_fetched_insn = w_hold_valid ? w_hold_insn : imem_data;

  // PC, fetch-tracking and IF/ID registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_f_valid    <= 1'b0;
      r_f_pc       <= RESET_PC;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_insn  <= NOP_INSN;
    end else begin
      case (w_act)
        ACT_REDIRECT: begin
          r_pc         <= redir_pc;
          r_f_valid    <= 1'b0;
          r_ifid_valid <= 1'b0;
          r_ifid_insn  <= NOP_INSN;
        end
        ACT_ADVANCE: begin
          r_ifid_valid <= r_f_valid;
          r_ifid_pc    <= r_f_pc;
          r_ifid_insn  <= r_f_valid ? w_fetched_insn : NOP_INSN;
          r_f_valid    <= 1'b1;
          r_f_pc       <= r_pc;
          r_pc         <= pc_inc(r_pc);
        end
        default: begin
          // Stall: everything here holds.
        end
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign ifid_valid = r_ifid_valid;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_insn  = r_ifid_insn;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: synchronous imem model, an abstract model of the
// expected IF/ID stream compared every cycle, plus directed literal checks.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              redir_valid;
  logic [PC_W-1:0]   redir_pc;
  logic [PC_W-1:0]   imem_addr;
  logic [INSN_W-1:0] imem_data;
  logic              ifid_valid;
  logic [PC_W-1:0]   ifid_pc;
  logic [INSN_W-1:0] ifid_insn;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clock       (clk),
    .reset       (rst_n),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .ifid_valid  (ifid_valid),
    .ifid_pc     (ifid_pc),
    .ifid_insn   (ifid_insn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSN_W-1:0] word(input logic [PC_W-1:0] a);
    return 32'hA000_0000 + {20'h0, a};
  endfunction

  // Synchronous instruction memory: data one cycle after the address.
  initial imem_data = '0;
  always @(posedge clk) imem_data <= word(imem_addr);

  // Abstract model: after reset/redirect to base, the k-th advancing edge
  // has the PC at base+k, and the IF/ID register shows base+k-2 once k>=2.
  logic [PC_W-1:0] m_base;
  int              m_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_base <= RESET_PC;
      m_k    <= 0;
    end else if (redir_valid) begin
      m_base <= redir_pc;
      m_k    <= 0;
    end else if (!stall) begin
      m_k    <= m_k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [PC_W-1:0] e_addr;
    logic [PC_W-1:0] e_pc;
    logic            e_valid;
    e_addr  = m_base + m_k[PC_W-1:0];
    e_valid = (m_k >= 2);
    e_pc    = m_base + m_k[PC_W-1:0] - 12'd2;
    chk("model_imem_addr", {20'h0, imem_addr}, {20'h0, e_addr});
    chk("model_ifid_valid", {31'h0, ifid_valid}, {31'h0, e_valid});
    if (e_valid) begin
      chk("model_ifid_pc", {20'h0, ifid_pc}, {20'h0, e_pc});
      chk("model_ifid_insn", ifid_insn, word(e_pc));
    end else begin
      chk("model_ifid_nop", ifid_insn, NOP_INSN);
    end
    if (!rst_n) chk("model_reset_pc", {20'h0, ifid_pc}, 32'h0);
    $display("cyc t=%0t rst_n=%0b st=%0b rv=%0b addr=%h v=%0b pc=%h insn=%h",
             $time, rst_n, stall, redir_valid, imem_addr, ifid_valid, ifid_pc, ifid_insn);
  end

  // Apply inputs at a falling edge, let one rising edge use them, and
  // return at the next falling edge.
  task automatic cyc(input logic st, input logic rv, input logic [PC_W-1:0] rp);
    stall       = st;
    redir_valid = rv;
    redir_pc    = rp;
    @(negedge clk);
  endtask

  task automatic expect_valid(input string name, input logic [PC_W-1:0] pc);
    chk({name, "_valid"}, {31'h0, ifid_valid}, 32'h1);
    chk({name, "_pc"}, {20'h0, ifid_pc}, {20'h0, pc});
    chk({name, "_insn"}, ifid_insn, word(pc));
  endtask

  task automatic expect_bubble(input string name);
    chk({name, "_valid"}, {31'h0, ifid_valid}, 32'h0);
    chk({name, "_insn"}, ifid_insn, NOP_INSN);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;

    // 1. Reset sequencing.
    repeat (3) @(negedge clk);
    chk("rst_addr", {20'h0, imem_addr}, 32'h0);
    expect_bubble("rst");
    rst_n = 1'b1;
    cyc(0, 0, 0);
    expect_bubble("rel_e1");
    cyc(0, 0, 0);
    expect_valid("rel_e2", 12'h000);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0);
      expect_valid("seq", i[PC_W-1:0]);
    end

    // 2. Stall for 4 cycles with ifid_pc=5.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      expect_valid("stall_hold", 12'h005);
      chk("stall_addr", {20'h0, imem_addr}, 32'h7);
    end
    cyc(0, 0, 0); expect_valid("post_stall6", 12'h006);
    cyc(0, 0, 0); expect_valid("post_stall7", 12'h007);
    cyc(0, 0, 0); expect_valid("post_stall8", 12'h008);

    // 3. Redirect to 0x100.
    cyc(0, 1, 12'h100);
    expect_bubble("redir_b1");
    chk("redir_addr", {20'h0, imem_addr}, 32'h100);
    cyc(0, 0, 0); expect_bubble("redir_b2");
    cyc(0, 0, 0); expect_valid("redir_100", 12'h100);
    cyc(0, 0, 0); expect_valid("redir_101", 12'h101);

    // 4. Load the hold buffer, then redirect during the stall.
    cyc(1, 0, 0);
    expect_valid("pre_rs_hold", 12'h101);
    cyc(1, 1, 12'h040);
    expect_bubble("rs_b0");
    cyc(1, 0, 0); expect_bubble("rs_b1");
    cyc(1, 0, 0); expect_bubble("rs_b2");
    cyc(0, 0, 0); expect_bubble("rs_b3");
    cyc(0, 0, 0); expect_valid("rs_040", 12'h040);
    cyc(0, 0, 0); expect_valid("rs_041", 12'h041);

    // 5. Wrap-around.
    cyc(0, 1, 12'hFFE);
    cyc(0, 0, 0);
    cyc(0, 0, 0); expect_valid("wrap_ffe", 12'hFFE);
    cyc(0, 0, 0); expect_valid("wrap_fff", 12'hFFF);
    cyc(0, 0, 0); expect_valid("wrap_000", 12'h000);
    cyc(0, 0, 0); expect_valid("wrap_001", 12'h001);

    // 6. Asynchronous reset mid-stall with the hold buffer loaded.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_addr", {20'h0, imem_addr}, 32'h0);
    chk("async_pc", {20'h0, ifid_pc}, 32'h0);
    expect_bubble("async");
    @(negedge clk);
    cyc(0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0); expect_bubble("rst2_e1");
    cyc(0, 0, 0); expect_valid("rst2_e2", 12'h000);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 24; i++) begin
      cyc((i % 5) == 2 || (i % 7) == 3, (i % 11) == 6, 12'h3F0 + i[PC_W-1:0]);
    end
    cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
